// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator with sub-word access, alignment checks and read-modify-write stores
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        mem_read,
    output logic        mem_write
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t      state, state_n;
    logic        wr_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, word_q, merge, load_v;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        req_err;
    assign req_err = req_size == 2'b11 || (req_size == 2'b01 && req_address[0])
                     || (req_size == 2'b10 && req_address[1:0] != 2'b00);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid) begin
                wr_q    <= req_write;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                size_q  <= req_size;
                addr_q  <= req_address;
                wdata_q <= req_wdata;
            end
            if (state == READ)
                word_q <= mem_read_data;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid)
                         state_n = req_err ? RESP : (!req_write || req_size != 2'b10) ? READ : WRITE;
            READ:    state_n = wr_q ? WRITE : RESP;
            WRITE:   state_n = RESP;
            default: state_n = IDLE;
        endcase
    end
    // Sub-word stores splice the new lane into the word captured during READ
    always_comb begin
        merge = word_q;
        if (size_q == 2'b00)
            merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (size_q == 2'b01)
            merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merge = wdata_q;
    end
    assign lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = word_q[{addr_q[1], 4'b0000} +: 16];
    assign load_v = size_q == 2'b00 ? {{24{~uns_q & lane_b[7]}}, lane_b}
                  : size_q == 2'b01 ? {{16{~uns_q & lane_h[15]}}, lane_h} : word_q;
    assign req_ready      = state == IDLE;
    assign mem_read       = state == READ;
    assign mem_write      = state == WRITE;
    assign mem_address    = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_write_data = mem_write ? merge : 32'd0;
    assign resp_valid     = state == RESP;
    assign resp_error     = resp_valid && err_q;
    assign resp_rdata     = (resp_valid && !err_q && !wr_q) ? load_v : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven scoreboard bench for load_store_unit against a word-wide memory model
module tb_load_store_unit;
    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] wd;
    } vec_t;
    typedef struct {
        int n;
        int rd;
        int wr;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_address = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_error, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
    logic [31:0] mem [0:63] = '{4: 32'h8BADF00D, default: 32'h0};

    int   checks = 0, errors = 0;
    int   nidx = 0, rd_cnt = 0, wr_cnt = 0, acc_total = 0, resp_total = 0;
    int   last_resp = 0, prev_resp = 0;
    vec_t exp_q[$];
    acc_t acc_q[$];
    vec_t e_cur;
    acc_t a_cur;
    vec_t tbl[20];

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read(mem_read), .mem_write(mem_write)
    );

    always #5 clk = ~clk;
    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk)
        if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err,
                                input int lat, input int rd, input int wr, input logic [31:0] wd);
        vec_t v;
        v = '{w, sz, u, addr, wdata, rdata, err, lat, rd, wr, wd};
        return v;
    endfunction

    // Scoreboard side: strobes, acceptances and responses observed away from the rising edge
    always @(negedge clk) begin
        nidx++;
        if (!reset) begin
            if (mem_read) begin
                rd_cnt++;
                if (exp_q.size() != 0) chk("rd_addr", mem_address, {exp_q[0].addr[31:2], 2'b00});
            end
            if (mem_write) begin
                wr_cnt++;
                if (exp_q.size() != 0) begin
                    chk("wr_addr", mem_address, {exp_q[0].addr[31:2], 2'b00});
                    chk("wr_data", mem_write_data, exp_q[0].wd);
                end
            end
            if (resp_valid) begin
                resp_total++;
                prev_resp = last_resp;
                last_resp = nidx;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp got rdata %h err %b want no response", resp_rdata, resp_error);
                end else begin
                    e_cur = exp_q.pop_front();
                    a_cur = acc_q.pop_front();
                    chk("rdata", resp_rdata, e_cur.rdata);
                    chk("error", {31'd0, resp_error}, {31'd0, e_cur.err});
                    chk("latency", nidx - a_cur.n, e_cur.lat);
                    chk("rd_strobes", rd_cnt - a_cur.rd, e_cur.rd);
                    chk("wr_strobes", wr_cnt - a_cur.wr, e_cur.wr);
                end
            end
            if (req_valid && req_ready) begin
                acc_q.push_back('{nidx, rd_cnt, wr_cnt});
                acc_total++;
            end
        end
    end

    task automatic drive(input vec_t v);
        req_write = v.w;
        req_size = v.sz;
        req_unsigned = v.u;
        req_address = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
    endtask

    task automatic send(input vec_t v, input bit push);
        int base;
        bit ok;
        @(posedge clk);
        #1;
        base = acc_total;
        ok = 1'b0;
        drive(v);
        if (push) exp_q.push_back(v);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            ok = acc_total != base;
        end
        #1 req_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got not accepted want accepted addr %h", v.addr);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            #1 ok = exp_q.size() == 0;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout got %0d pending want 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    initial begin
        vec_t lw10;
        int base, busy, wr0;
        bit seen;
        lw10 = mk(0, 2'b10, 0, 32'h10, 0, 32'h8BADF00D, 0, 2, 1, 0, 0);
        tbl[0]  = mk(0, 2'b10, 0, 32'h10, 0, 32'h8BADF00D, 0, 2, 1, 0, 0);
        tbl[1]  = mk(0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF8B, 0, 2, 1, 0, 0);
        tbl[2]  = mk(0, 2'b00, 1, 32'h13, 0, 32'h0000008B, 0, 2, 1, 0, 0);
        tbl[3]  = mk(0, 2'b01, 0, 32'h12, 0, 32'hFFFF8BAD, 0, 2, 1, 0, 0);
        tbl[4]  = mk(0, 2'b01, 1, 32'h10, 0, 32'h0000F00D, 0, 2, 1, 0, 0);
        tbl[5]  = mk(0, 2'b00, 0, 32'h11, 0, 32'hFFFFFFF0, 0, 2, 1, 0, 0);
        tbl[6]  = mk(1, 2'b00, 0, 32'h11, 32'h12345678, 0, 0, 3, 1, 1, 32'h8BAD780D);
        tbl[7]  = mk(0, 2'b10, 0, 32'h10, 0, 32'h8BAD780D, 0, 2, 1, 0, 0);
        tbl[8]  = mk(1, 2'b01, 0, 32'h11, 32'hFFFF, 0, 1, 1, 0, 0, 0);
        tbl[9]  = mk(0, 2'b10, 0, 32'h12, 0, 0, 1, 1, 0, 0, 0);
        tbl[10] = mk(0, 2'b11, 0, 32'h10, 0, 0, 1, 1, 0, 0, 0);
        tbl[11] = mk(1, 2'b10, 0, 32'h21, 32'h11111111, 0, 1, 1, 0, 0, 0);
        tbl[12] = mk(1, 2'b10, 0, 32'h20, 32'hCAFEBABE, 0, 0, 2, 0, 1, 32'hCAFEBABE);
        tbl[13] = mk(0, 2'b10, 1, 32'h20, 0, 32'hCAFEBABE, 0, 2, 1, 0, 0);
        tbl[14] = mk(1, 2'b01, 0, 32'h22, 32'h1234BEEF, 0, 0, 3, 1, 1, 32'hBEEFBABE);
        tbl[15] = mk(0, 2'b01, 1, 32'h22, 0, 32'h0000BEEF, 0, 2, 1, 0, 0);
        tbl[16] = mk(0, 2'b01, 0, 32'h22, 0, 32'hFFFFBEEF, 0, 2, 1, 0, 0);
        tbl[17] = mk(1, 2'b00, 0, 32'h20, 32'h000000AA, 0, 0, 3, 1, 1, 32'hBEEFBAAA);
        tbl[18] = mk(0, 2'b00, 0, 32'h21, 0, 32'hFFFFFFBA, 0, 2, 1, 0, 0);
        tbl[19] = mk(0, 2'b10, 0, 32'h20, 0, 32'hBEEFBAAA, 0, 2, 1, 0, 0);

        #3;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset landing in the READ cycle of a sub-word store
        wr0 = wr_cnt;
        send(mk(1, 2'b01, 0, 32'h10, 32'h5555, 0, 0, 3, 1, 1, 0), 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_read;
        end
        chk("midrst_read_seen", {31'd0, seen}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("midrst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        acc_q.delete();
        repeat (4) @(negedge clk);
        chk("midrst_no_write", wr_cnt - wr0, 32'd0);
        chk("midrst_mem_kept", mem[4], 32'h8BADF00D);
        send(lw10, 1'b1);
        wait_idle();

        // Back-to-back loads with req_valid held high
        base = acc_total;
        busy = 0;
        exp_q.push_back(lw10);
        exp_q.push_back(lw10);
        @(posedge clk);
        #1 drive(lw10);
        for (int i = 0; i < 20 && acc_total - base < 2; i++) begin
            @(posedge clk);
            #1;
            if (acc_total - base == 1 && !req_ready) busy++;
        end
        req_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("b2b_accepts", acc_total - base, 32'd2);
        chk("b2b_busy_cycles", busy, 32'd2);
        chk("b2b_resp_gap", last_resp - prev_resp, 32'd3);

        base = resp_total;
        for (int i = 0; i < 20; i++) begin
            send(tbl[i], 1'b1);
            wait_idle();
        end
        chk("table_resp_count", resp_total - base, 32'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end
endmodule
